// File: rtl/noc_output_allocator.sv
`default_nettype none
// ============================================================================
// Module  : noc_output_allocator
// Desc    : Round-robin, packet-granular output allocator with credit flow
//           control; ALLOC_TIMEOUT_EN adds an idle-lock forced release.
// Rev     : 1.0
// ============================================================================
module noc_output_allocator #(
   parameter int CREDITS = 4,
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] req,
   input  logic [4:0] tail,
   input  logic       flit_valid,
   input  logic       credit_in,
   output logic [4:0] grant,
   output logic [2:0] grant_idx,
   output logic       busy,
   output logic       xfer,
   output logic [3:0] credits,
   output logic       credit_err,
   output logic       timeout
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   localparam logic [3:0] c_credit_max = 4'(CREDITS);

   state_t     r_state, w_state_nxt;
   logic [2:0] r_ptr, w_ptr_nxt;
   logic [4:0] r_grant, w_grant_nxt;
   logic [2:0] r_grant_idx, w_grant_idx_nxt;
   logic [3:0] r_credits;
   logic       r_credit_err;
   logic       w_xfer, w_release, w_found, w_to_hit;
   logic [2:0] w_pick, w_cand;
   logic [3:0] w_sum;

   assign w_xfer    = (r_state == S_BUSY) & flit_valid & (r_credits != 4'd0);
   assign w_release = (w_xfer & tail[r_grant_idx]) | w_to_hit;

   // First requester at or after the pointer, wrapping modulo 5.
   always_comb begin
      w_found = 1'b0;
      w_pick  = 3'd0;
      w_cand  = 3'd0;
      w_sum   = 4'd0;
      for (int k = 0; k < 5; k++) begin
         w_sum  = {1'b0, r_ptr} + 4'(k);
         w_cand = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_ptr_nxt       = r_ptr;
      w_grant_nxt     = r_grant;
      w_grant_idx_nxt = r_grant_idx;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt     = S_BUSY;
               w_grant_nxt     = 5'b00001 << w_pick;
               w_grant_idx_nxt = w_pick;
            end
         end
         S_BUSY: begin
            if (w_release) begin
               w_state_nxt     = S_IDLE;
               w_grant_nxt     = 5'd0;
               w_grant_idx_nxt = 3'd0;
               w_ptr_nxt       = (r_grant_idx == 3'd4) ? 3'd0 : r_grant_idx + 3'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ptr       <= 3'd0;
         r_grant     <= 5'd0;
         r_grant_idx <= 3'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_grant     <= w_grant_nxt;
         r_grant_idx <= w_grant_idx_nxt;
      end
   end

   // A return with no transfer while already full saturates and flags an error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_credits    <= c_credit_max;
         r_credit_err <= 1'b0;
      end else begin
         case ({w_xfer, credit_in})
            2'b10: r_credits <= r_credits - 4'd1;
            2'b01: begin
               if (r_credits == c_credit_max) r_credit_err <= 1'b1;
               else                           r_credits    <= r_credits + 4'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef ALLOC_TIMEOUT_EN
   logic [4:0] r_idle_cnt;
   logic       r_timeout;

   assign w_to_hit = (r_state == S_BUSY) & ~w_xfer & (r_idle_cnt == 5'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idle_cnt <= 5'd0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= w_to_hit;
         if ((r_state != S_BUSY) || w_xfer || w_to_hit) r_idle_cnt <= 5'd0;
         else                                           r_idle_cnt <= r_idle_cnt + 5'd1;
      end
   end

   assign timeout = r_timeout;
`else
   assign w_to_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   assign grant      = r_grant;
   assign grant_idx  = r_grant_idx;
   assign busy       = (r_state == S_BUSY);
   assign xfer       = w_xfer;
   assign credits    = r_credits;
   assign credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_output_allocator.sv
`default_nettype none
// ============================================================================
// Module  : tb_noc_output_allocator
// Desc    : Directed self-checking bench with a grant-order scoreboard.
// Rev     : 1.0
// ============================================================================
module tb_noc_output_allocator;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] req, tail;
   logic       flit_valid, credit_in;
   logic [4:0] grant;
   logic [2:0] grant_idx;
   logic       busy, xfer, credit_err, timeout;
   logic [3:0] credits;

   int n_cmp = 0;
   int n_err = 0;
   int q_exp[$];
   int m_ptr;

   noc_output_allocator #(.CREDITS(4), .TIMEOUT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .tail       (tail),
      .flit_valid (flit_valid),
      .credit_in  (credit_in),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .busy       (busy),
      .xfer       (xfer),
      .credits    (credits),
      .credit_err (credit_err),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Each packet is one flit; the credit is returned in the same cycle so the count holds.
   task automatic run_pkts(input int n);
      int         e;
      logic [4:0] oh;
      for (int i = 0; i < n; i++) begin
         cyc();
         if (q_exp.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL rr_queue: observed=empty expected=entry");
            e = 0;
         end else begin
            e = q_exp.pop_front();
         end
         oh = 5'b00001 << e;
         chk("rr_grant", 8'(grant), 8'(oh));
         chk("rr_idx", 8'(grant_idx), 8'(e));
         credit_in = 1'b1;
         #1;
         chk("rr_xfer", 8'(xfer), 8'd1);
         cyc();
         credit_in = 1'b0;
         chk("rr_gap", 8'(grant), 8'd0);
         chk("rr_credits", 8'(credits), 8'd4);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; req = 5'd0; tail = 5'd0; flit_valid = 1'b0; credit_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_grant", 8'(grant), 8'd0);
      chk("rst_idx", 8'(grant_idx), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_credits", 8'(credits), 8'd4);
      chk("rst_err", 8'(credit_err), 8'd0);
      chk("rst_timeout", 8'(timeout), 8'd0);
      m_ptr = 0;

      // 3-flit packet from L
      req = 5'b00001;
      cyc();
      chk("t1_grant", 8'(grant), 8'h01);
      chk("t1_busy", 8'(busy), 8'd1);
      flit_valid = 1'b1;
      #1 chk("t1_xfer1", 8'(xfer), 8'd1);
      cyc();
      chk("t1_cred3", 8'(credits), 8'd3);
      #1 chk("t1_xfer2", 8'(xfer), 8'd1);
      cyc();
      chk("t1_cred2", 8'(credits), 8'd2);
      tail = 5'b00001;
      #1 chk("t1_xfer3", 8'(xfer), 8'd1);
      cyc();
      req = 5'd0; flit_valid = 1'b0; tail = 5'd0;
      chk("t1_release", 8'(grant), 8'd0);
      chk("t1_busy0", 8'(busy), 8'd0);
      chk("t1_cred1", 8'(credits), 8'd1);
      m_ptr = 1;
      credit_in = 1'b1;
      repeat (3) cyc();
      credit_in = 1'b0;
      chk("t1_refill", 8'(credits), 8'd4);
      chk("t1_err", 8'(credit_err), 8'd0);

      // All ports request, single-flit packets
      req = 5'b11111; flit_valid = 1'b1; tail = 5'b11111;
      for (int k = 0; k < 6; k++) q_exp.push_back((m_ptr + k) % 5);
      run_pkts(6);
      req = 5'd0;
      m_ptr = (m_ptr + 6) % 5;
      chk("t2_err", 8'(credit_err), 8'd0);

      // 6-flit packet from N with no returning credits
      req = 5'b00010; tail = 5'd0; flit_valid = 1'b1;
      cyc();
      chk("t3_grant", 8'(grant), 8'h02);
      for (int k = 0; k < 4; k++) begin
         #1 chk("t3_xfer", 8'(xfer), 8'd1);
         cyc();
      end
      chk("t3_cred0", 8'(credits), 8'd0);
      #1 chk("t3_stall", 8'(xfer), 8'd0);
      cyc();
      chk("t3_hold", 8'(grant), 8'h02);
      chk("t3_busy", 8'(busy), 8'd1);
      credit_in = 1'b1;
      cyc();
      credit_in = 1'b0;
      chk("t3_cred1", 8'(credits), 8'd1);
      #1 chk("t3_xfer5", 8'(xfer), 8'd1);
      cyc();
      chk("t3_cred0b", 8'(credits), 8'd0);
      chk("t3_hold2", 8'(grant), 8'h02);
      credit_in = 1'b1;
      cyc();
      credit_in = 1'b0;
      tail = 5'b00010;
      #1 chk("t3_xfer6", 8'(xfer), 8'd1);
      cyc();
      req = 5'd0; flit_valid = 1'b0; tail = 5'd0;
      chk("t3_release", 8'(grant), 8'd0);
      chk("t3_cred_end", 8'(credits), 8'd0);
      m_ptr = 2;
      credit_in = 1'b1;
      repeat (4) cyc();
      credit_in = 1'b0;
      chk("t3_refill", 8'(credits), 8'd4);

      // S, then L and W contend; then wrap search from S
      req = 5'b10000; flit_valid = 1'b1; tail = 5'b11111;
      q_exp.push_back(4);
      run_pkts(1);
      req = 5'b01001;
      q_exp.push_back(0);
      q_exp.push_back(3);
      run_pkts(2);
      req = 5'b00011;
      q_exp.push_back(0);
      run_pkts(1);
      req = 5'd0; flit_valid = 1'b0; tail = 5'd0;

      // Credit overflow and simultaneous xfer/credit_in
      credit_in = 1'b1;
      cyc();
      credit_in = 1'b0;
      chk("t5_err", 8'(credit_err), 8'd1);
      chk("t5_sat", 8'(credits), 8'd4);
      cyc();
      chk("t5_sticky", 8'(credit_err), 8'd1);
      req = 5'b00100; flit_valid = 1'b1;
      cyc();
      chk("t5_grant", 8'(grant), 8'h04);
      credit_in = 1'b1;
      #1 chk("t5_xfer", 8'(xfer), 8'd1);
      cyc();
      credit_in = 1'b0;
      chk("t5_both", 8'(credits), 8'd4);
      tail = 5'b00100;
      cyc();
      req = 5'd0; flit_valid = 1'b0; tail = 5'd0;
      chk("t5_dec", 8'(credits), 8'd3);
      chk("t5_release", 8'(grant), 8'd0);
      credit_in = 1'b1;
      cyc();
      credit_in = 1'b0;
      chk("t5_refill", 8'(credits), 8'd4);
      chk("t5_sticky2", 8'(credit_err), 8'd1);

      // Asynchronous reset mid-packet
      req = 5'b00001; flit_valid = 1'b1;
      cyc();
      chk("t6_grant", 8'(grant), 8'h01);
      cyc();
      chk("t6_cred3", 8'(credits), 8'd3);
      #2 reset = 1'b1;
      #1;
      chk("t6_grant0", 8'(grant), 8'd0);
      chk("t6_busy0", 8'(busy), 8'd0);
      chk("t6_cred4", 8'(credits), 8'd4);
      chk("t6_err0", 8'(credit_err), 8'd0);
      req = 5'd0; flit_valid = 1'b0;
      cyc();
      reset = 1'b0;

`ifdef ALLOC_TIMEOUT_EN
      req = 5'b00100;
      cyc();
      req = 5'd0;
      chk("to_grant", 8'(grant), 8'h04);
      repeat (15) cyc();
      chk("to_hold", 8'(grant), 8'h04);
      chk("to_nopulse", 8'(timeout), 8'd0);
      cyc();
      chk("to_release", 8'(grant), 8'd0);
      chk("to_pulse", 8'(timeout), 8'd1);
      req = 5'b01001;
      cyc();
      req = 5'd0;
      chk("to_pulse_end", 8'(timeout), 8'd0);
      chk("to_next_w", 8'(grant), 8'h08);
`else
      req = 5'b00100;
      cyc();
      req = 5'd0;
      repeat (20) cyc();
      chk("nt_hold", 8'(grant), 8'h04);
      chk("nt_timeout", 8'(timeout), 8'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
